// File: rtl/note_decoder_seq_if.sv
// note_decoder_seq_if: frequency request handshake and note result bundle.
// master drives freq/in_valid; slave (decoder) returns in_ready and results.
interface note_decoder_seq_if #(
  parameter int FREQ_W = 16
);
  logic [FREQ_W-1:0] freq;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        letter;
  logic [7:0]        sharp;
  logic [7:0]        number;
  logic              err;
  logic              out_valid;

  modport master (
    output freq, in_valid,
    input  in_ready, letter, sharp, number, err, out_valid
  );

  modport slave (
    input  freq, in_valid,
    output in_ready, letter, sharp, number, err, out_valid
  );
endinterface

// File: rtl/note_decoder_seq.sv
// note_decoder_seq: iterative frequency-to-note decoder (octave norm + scan).
// Optional NOTE_STABLE_EN: publish only after STABLE_COUNT agreeing results.
module note_decoder_seq #(
  parameter int FREQ_W       = 16,
  parameter int FRAC_W       = 0,
  parameter int STABLE_COUNT = 2
) (
  input logic               clk,
  input logic               reset,
  note_decoder_seq_if.slave bus
);
  localparam int VW = FREQ_W + 12;

  typedef enum logic [1:0] {IDLE, NORM, SCAN, DONE} state_e;

  typedef struct packed {
    logic [7:0] letter;
    logic [7:0] sharp;
    logic [7:0] number;
    logic       err;
  } note_t;

  localparam note_t NOTE_ERR = '{8'h2D, 8'h20, 8'h2D, 1'b1};
  localparam note_t NOTE_RST = '{8'h2D, 8'h20, 8'h2D, 1'b0};

  localparam logic [VW-1:0] LO  = VW'(65070);
  localparam logic [VW-1:0] TOP = VW'(130140);

  if (FRAC_W < 0 || FRAC_W > 8 || STABLE_COUNT < 1) begin : g_bad_cfg
    $error("note_decoder_seq: illegal parameter");
  end

  function automatic logic [VW-1:0] ubound(input logic [3:0] k);
    case (k)
      4'd0:    ubound = VW'(68938);
      4'd1:    ubound = VW'(73037);
      4'd2:    ubound = VW'(77381);
      4'd3:    ubound = VW'(81981);
      4'd4:    ubound = VW'(86858);
      4'd5:    ubound = VW'(92022);
      4'd6:    ubound = VW'(97495);
      4'd7:    ubound = VW'(103291);
      4'd8:    ubound = VW'(109432);
      4'd9:    ubound = VW'(115940);
      4'd10:   ubound = VW'(122834);
      default: ubound = TOP;
    endcase
  endfunction

  function automatic note_t note_of(input logic [3:0] idx,
                                    input logic [3:0] oct);
    note_t n;
    n.err    = 1'b0;
    n.number = 8'h30 + {4'h0, oct};
    n.sharp  = 8'h20;
    case (idx)
      4'd0, 4'd1:  n.letter = 8'h43;
      4'd2, 4'd3:  n.letter = 8'h44;
      4'd4:        n.letter = 8'h45;
      4'd5, 4'd6:  n.letter = 8'h46;
      4'd7, 4'd8:  n.letter = 8'h47;
      4'd9, 4'd10: n.letter = 8'h41;
      default:     n.letter = 8'h42;
    endcase
    if (idx == 4'd1 || idx == 4'd3 || idx == 4'd6 ||
        idx == 4'd8 || idx == 4'd10)
      n.sharp = 8'h23;
    return n;
  endfunction

  state_e        state_q;
  logic [VW-1:0] v_q;
  logic [3:0]    oct_q;
  logic [3:0]    k_q;
  note_t         res_q;
  logic          ov_q;

  logic          fin;
  note_t         res;
  logic [VW-1:0] uk;

  // fin marks the cycle a conversion resolves; res is its result
  always_comb begin
    fin = 1'b0;
    res = NOTE_ERR;
    uk  = ubound(k_q);
    unique case (state_q)
      NORM: begin
        if (v_q == '0 ||
            (v_q < LO && oct_q == 4'd0) ||
            (v_q >= TOP && oct_q == 4'd9))
          fin = 1'b1;
      end
      SCAN: begin
        if (v_q < uk) begin
          fin = 1'b1;
          res = note_of(k_q, oct_q);
        end
      end
      default: ;
    endcase
  end

`ifdef NOTE_STABLE_EN
  localparam logic [7:0] SC = 8'(STABLE_COUNT);
  note_t      cand_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       pub;

  always_comb begin
    if (res == cand_q)
      cnt_d = (cnt_q < SC) ? cnt_q + 8'd1 : cnt_q;
    else
      cnt_d = 8'd1;
    pub = (cnt_d >= SC);
  end
`else
  logic pub;
  assign pub = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      v_q     <= '0;
      oct_q   <= 4'd4;
      k_q     <= 4'd0;
      res_q   <= NOTE_RST;
      ov_q    <= 1'b0;
`ifdef NOTE_STABLE_EN
      cand_q  <= '0;
      cnt_q   <= 8'd0;
`endif
    end else begin
      ov_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            v_q     <= VW'(bus.freq) << (8 - FRAC_W);
            oct_q   <= 4'd4;
            k_q     <= 4'd0;
            state_q <= NORM;
          end
        end
        NORM: begin
          if (fin) begin
            state_q <= DONE;
          end else if (v_q < LO) begin
            v_q   <= v_q << 1;
            oct_q <= oct_q - 4'd1;
          end else if (v_q >= TOP) begin
            v_q   <= v_q >> 1;
            oct_q <= oct_q + 4'd1;
          end else begin
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (fin) state_q <= DONE;
          else     k_q <= k_q + 4'd1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (fin) begin
`ifdef NOTE_STABLE_EN
        cand_q <= res;
        cnt_q  <= cnt_d;
`endif
        if (pub) begin
          res_q <= res;
          ov_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.letter    = res_q.letter;
  assign bus.sharp     = res_q.sharp;
  assign bus.number    = res_q.number;
  assign bus.err       = res_q.err;
  assign bus.out_valid = ov_q;
endmodule

// File: tb/tb_note_decoder_seq.sv
// tb_note_decoder_seq: random + directed checks against a note reference model.
// Covers latency, errors, busy input, reset abort, FRAC_W=4, NOTE_STABLE_EN.
module tb_note_decoder_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  note_decoder_seq_if #(.FREQ_W(16)) bus ();
  note_decoder_seq_if #(.FREQ_W(20)) bus4 ();

  note_decoder_seq #(
    .FREQ_W(16), .FRAC_W(0), .STABLE_COUNT(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  note_decoder_seq #(
    .FREQ_W(20), .FRAC_W(4), .STABLE_COUNT(2)
  ) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave)
  );

  int tests = 0;
  int fails = 0;
  longint ub[12];
  longint lo;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic build_table();
    real ubr[12];
    ubr = '{269.29, 285.30, 302.27, 320.24, 339.29, 359.46,
            380.84, 403.48, 427.47, 452.89, 479.82, 508.36};
    for (int k = 0; k < 12; k++) ub[k] = $rtoi(ubr[k] * 256.0 + 0.5);
    lo = $rtoi(254.18 * 256.0 + 0.5);
  endtask

  // Octave folding by doubling/halving, then semitone lookup by bound table
  function automatic void model(input longint f, input int fw,
                                output logic [7:0] l, output logic [7:0] s,
                                output logic [7:0] n, output logic e,
                                output int lat);
    longint v;
    int oct, sh, idx;
    bit ok;
    string names;
    names = "CCDDEFFGGAAB";
    v = f << (8 - fw);
    oct = 4; sh = 0; e = 1'b0; ok = 1'b0;
    while (!ok && !e) begin
      if (v == 0) e = 1'b1;
      else if (v < lo) begin
        if (oct == 0) e = 1'b1;
        else begin v = v * 2; oct--; sh++; end
      end else if (v >= ub[11]) begin
        if (oct == 9) e = 1'b1;
        else begin v = v / 2; oct++; sh++; end
      end else ok = 1'b1;
    end
    idx = 0;
    while (idx < 11 && v >= ub[idx]) idx++;
    if (e) begin
      l = 8'h2D; s = 8'h20; n = 8'h2D; lat = 1 + sh;
    end else begin
      l = names[idx];
      s = (idx inside {1, 3, 6, 8, 10}) ? 8'h23 : 8'h20;
      n = 8'h30 + 8'(oct);
      lat = 2 + sh + idx;
    end
  endfunction

  task automatic conv(input logic [15:0] f, input bit pub,
                      input int pulse_f, input string tag);
    logic [7:0] el, es, en;
    logic ee;
    int elat, lat, w;
    bit got;
    model(longint'(f), 0, el, es, en, ee, elat);
    w = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && w < 50) begin
      @(negedge clk); w++;
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s idle: in_ready=%b want 1", tag, bus.in_ready);
      return;
    end
    bus.freq = f;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s busy: in_ready=%b want 0", tag, bus.in_ready);
    end
    got = 1'b0; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      if (pulse_f >= 0 && i == 3) begin
        bus.freq = 16'(pulse_f); bus.in_valid = 1'b1;
      end
      if (i == 4) bus.in_valid = 1'b0;
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin got = 1'b1; lat = i; break; end
      if (!pub && bus.in_ready === 1'b1) break;
    end
    tests++;
    if (got !== pub) begin
      fails++;
      $display("FAIL %s publish: out_valid seen=%0d want %0d", tag, got, pub);
    end
    if (got) begin
      tests++;
      if ({bus.letter, bus.sharp, bus.number, bus.err} !== {el, es, en, ee}) begin
        fails++;
        $display("FAIL %s result: got %h %h %h err=%b want %h %h %h err=%b",
                 tag, bus.letter, bus.sharp, bus.number, bus.err,
                 el, es, en, ee);
      end
      if (!ee) begin
        tests++;
        if (lat != elat) begin
          fails++;
          $display("FAIL %s latency: got %0d want %0d", tag, lat, elat);
        end
      end
      @(posedge clk); #1;
      tests++;
      if (bus.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL %s pulse: out_valid=%b want 0", tag, bus.out_valid);
      end
    end
  endtask

  task automatic conv4(input logic [19:0] f, input string tag);
    logic [7:0] el, es, en;
    logic ee;
    int elat, lat;
    bit got;
    model(longint'(f), 4, el, es, en, ee, elat);
    @(negedge clk);
    bus4.freq = f;
    bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    got = 1'b0; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus4.out_valid === 1'b1) begin got = 1'b1; lat = i; break; end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s publish: no out_valid within 40 edges", tag);
      return;
    end
    tests++;
    if ({bus4.letter, bus4.sharp, bus4.number, bus4.err} !== {el, es, en, ee}) begin
      fails++;
      $display("FAIL %s result: got %h %h %h err=%b want %h %h %h err=%b",
               tag, bus4.letter, bus4.sharp, bus4.number, bus4.err,
               el, es, en, ee);
    end
    if (!ee) begin
      tests++;
      if (lat != elat) begin
        fails++;
        $display("FAIL %s latency: got %0d want %0d", tag, lat, elat);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.freq = '0; bus.in_valid = 1'b0;
    bus4.freq = '0; bus4.in_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.letter, bus.sharp, bus.number} !== 24'h2D202D) begin
      fails++;
      $display("FAIL reset text: got %h want 2d202d",
               {bus.letter, bus.sharp, bus.number});
    end
    tests++;
    if ({bus.err, bus.out_valid, bus.in_ready} !== 3'b001) begin
      fails++;
      $display("FAIL reset flags: err/ov/rdy=%b want 001",
               {bus.err, bus.out_valid, bus.in_ready});
    end
    tests++;
    if (bus4.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset ready4: got %b want 1", bus4.in_ready);
    end
    reset = 1'b1;
  endtask

  task automatic test_directed();
    conv(16'd440, 1'b1, -1, "a440");
    conv(16'd261, 1'b1, -1, "c4");
    conv(16'd880, 1'b1, -1, "a5");
    conv(16'd277, 1'b1, -1, "cs4");
    conv(16'd27, 1'b1, -1, "a0");
  endtask

  task automatic test_errors();
    conv(16'd0, 1'b1, -1, "err_zero");
    conv(16'd15, 1'b1, -1, "err_under");
    conv(16'd20000, 1'b1, -1, "err_over");
    conv(16'd440, 1'b1, -1, "err_clear");
  endtask

  task automatic test_busy_ignore();
    conv(16'd440, 1'b1, 1000, "busy_in");
  endtask

  task automatic test_reset_mid_scan();
    int w;
    bit seen;
    w = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && w < 50) begin
      @(negedge clk); w++;
    end
    bus.freq = 16'd880;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    tests++;
    if ({bus.letter, bus.sharp, bus.number} !== 24'h2D202D) begin
      fails++;
      $display("FAIL abort text: got %h want 2d202d",
               {bus.letter, bus.sharp, bus.number});
    end
    tests++;
    if ({bus.err, bus.out_valid, bus.in_ready} !== 3'b001) begin
      fails++;
      $display("FAIL abort flags: err/ov/rdy=%b want 001",
               {bus.err, bus.out_valid, bus.in_ready});
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL abort pulse: out_valid seen=1 want 0");
    end
  endtask

  task automatic test_random();
    logic [15:0] f;
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) f = 16'($urandom_range(1, 65535));
      else            f = 16'($urandom_range(1, 1000));
      conv(f, 1'b1, -1, $sformatf("rand%0d_f%0d", i, f));
    end
  endtask

  task automatic test_frac4();
    conv4(20'd80000, "frac4_ds8");
    conv4(20'd7040, "frac4_a4");
    for (int i = 0; i < 4; i++)
      conv4(20'($urandom_range(1, 1048575)), $sformatf("frac4_rand%0d", i));
  endtask

  task automatic test_stable();
    conv(16'd440, 1'b0, -1, "stab1");
    conv(16'd441, 1'b1, -1, "stab2");
    conv(16'd880, 1'b0, -1, "stab3");
    conv(16'd880, 1'b1, -1, "stab4");
  endtask

  initial begin
    build_table();
    test_reset();
`ifdef NOTE_STABLE_EN
    test_stable();
`else
    test_directed();
    test_errors();
    test_busy_ignore();
    test_reset_mid_scan();
    test_random();
    test_frac4();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
